// File: rtl/drive_pkg.sv
// Shared encodings for the line-following drive controller and the motor wrapper.
package drive_pkg;

    // Width of the ultrasonic range input, in cm.
    localparam int DIST_W = 20;

    // Motor command driven to the motor wrapper.
    typedef enum logic [1:0] {
        MODE_STOP    = 2'b00,
        MODE_FORWARD = 2'b01,
        MODE_LEFT    = 2'b10,
        MODE_RIGHT   = 2'b11
    } mode_t;

    // Line tracker sensor summary.
    typedef enum logic [1:0] {
        TRK_CENTRE = 2'b00,
        TRK_LEFT   = 2'b01,
        TRK_RIGHT  = 2'b10,
        TRK_LOST   = 2'b11
    } tracker_t;

    // Controller state; the encoding is shown on the 7-seg/LED display.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FOLLOW  = 3'd1,
        ST_BLOCKED = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Counter width for a counter running 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Steering command that follows the line for a given tracker reading.
    function automatic mode_t target_mode(input tracker_t trk);
        case (trk)
            TRK_LEFT:  return MODE_LEFT;
            TRK_RIGHT: return MODE_RIGHT;
            default:   return MODE_FORWARD;
        endcase
    endfunction

endpackage

// File: rtl/drive_debounce.sv
// Obstacle detector: threshold compare with release hysteresis, then a
// consecutive-sample debounce before the registered obstacle flag moves.
module drive_debounce
    import drive_pkg::*;
#(
    parameter int OBST_CM    = 20,
    parameter int HYST_CM    = 5,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] distance,
    output logic              obstacle
);

    localparam int                CW        = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [DIST_W-1:0] NEAR_LIM  = DIST_W'(OBST_CM);
    localparam logic [DIST_W-1:0] CLEAR_LIM = DIST_W'(OBST_CM + HYST_CM);

    logic          raw_q;
    logic          raw_now;
    logic [CW-1:0] cnt;
    logic          obst_q;

    // Raw near/clear decision; inside the hysteresis band the last decision holds.
    always_comb begin
        // NOTE: default first so every path assigns raw_now and no latch is inferred.
        raw_now = raw_q;
        if (distance < NEAR_LIM) begin
            raw_now = 1'b1;
        end else if (distance >= CLEAR_LIM) begin
            raw_now = 1'b0;
        end
    end

    // Debounce: flip the flag once the raw condition has disagreed with it for
    // DEB_CYCLES consecutive samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            raw_q  <= 1'b0;
            cnt    <= '0;
            obst_q <= 1'b0;
        end else begin
            raw_q <= raw_now;
            if (raw_now == obst_q) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                obst_q <= raw_now;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign obstacle = obst_q;

endmodule

// File: rtl/drive_ctrl.sv
// Line-following drive controller: follows the tracker with a minimum mode
// dwell, searches when the line is lost, stops for debounced obstacles and
// halts when the search times out.
module drive_ctrl
    import drive_pkg::*;
#(
    parameter int OBST_CM       = 20,
    parameter int HYST_CM       = 5,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int HOLD_CYCLES   = 2_000_000,
    parameter int SEARCH_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIST_W-1:0] distance,
    input  logic [1:0]        tracker_state,
    output logic [1:0]        mode,
    output logic [2:0]        fsm_state,
    output logic              obstacle,
    output logic              halted
);

    localparam int            HW        = cnt_width(HOLD_CYCLES);
    localparam int            SW        = cnt_width(SEARCH_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] SRCH_LAST = SW'(SEARCH_CYCLES - 1);

    state_t        state, state_next;
    mode_t         mode_q, mode_next;
    mode_t         last_turn, last_turn_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic [SW-1:0] srch_cnt, srch_next;
    tracker_t      trk;
    logic          obst;

    assign trk = tracker_t'(tracker_state);

    drive_debounce #(
        .OBST_CM    (OBST_CM),
        .HYST_CM    (HYST_CM),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .distance (distance),
        .obstacle (obst)
    );

    // State register together with the registered mode, counters and last turn.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_STOP;
            last_turn <= MODE_LEFT;
            hold_cnt  <= '0;
            srch_cnt  <= '0;
        end else begin
            state     <= state_next;
            mode_q    <= mode_next;
            last_turn <= last_turn_next;
            hold_cnt  <= hold_next;
            srch_cnt  <= srch_next;
        end
    end

    // Next-state logic; enable low wins, then obstacle, then tracker/timeout.
    always_comb begin
        state_next     = state;
        mode_next      = mode_q;
        last_turn_next = last_turn;
        hold_next      = hold_cnt;
        srch_next      = srch_cnt;

        if (!enable) begin
            state_next = ST_IDLE;
            mode_next  = MODE_STOP;
            hold_next  = '0;
            srch_next  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_FOLLOW;
                    mode_next  = MODE_STOP;
                    hold_next  = '0;
                end

                ST_FOLLOW: begin
                    if (obst) begin
                        state_next = ST_BLOCKED;
                        mode_next  = MODE_STOP;
                        hold_next  = '0;
                        srch_next  = '0;
                    end else if (trk == TRK_LOST) begin
                        state_next = ST_SEARCH;
                        mode_next  = last_turn;
                        srch_next  = '0;
                    end else if (target_mode(trk) != mode_q &&
                                 (mode_q == MODE_STOP || hold_cnt == HOLD_LAST)) begin
                        // Leaving STOP is immediate; any other change waits out the dwell.
                        mode_next = target_mode(trk);
                        hold_next = '0;
                        if (target_mode(trk) == MODE_LEFT || target_mode(trk) == MODE_RIGHT) begin
                            last_turn_next = target_mode(trk);
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end

                ST_SEARCH: begin
                    if (obst) begin
                        state_next = ST_BLOCKED;
                        mode_next  = MODE_STOP;
                        srch_next  = '0;
                    end else if (trk != TRK_LOST) begin
                        state_next = ST_FOLLOW;
                        mode_next  = MODE_FORWARD;
                        hold_next  = '0;
                        srch_next  = '0;
                    end else if (srch_cnt == SRCH_LAST) begin
                        state_next = ST_HALT;
                        mode_next  = MODE_STOP;
                    end else begin
                        srch_next = srch_cnt + 1'b1;
                    end
                end

                ST_BLOCKED: begin
                    mode_next = MODE_STOP;
                    srch_next = '0;
                    if (!obst) begin
                        state_next = ST_FOLLOW;
                        mode_next  = MODE_FORWARD;
                        hold_next  = '0;
                    end
                end

                ST_HALT: begin
                    mode_next = MODE_STOP;
                end

                default: begin
                    state_next = ST_IDLE;
                    mode_next  = MODE_STOP;
                    hold_next  = '0;
                    srch_next  = '0;
                end
            endcase
        end
    end

    // Display and status outputs decoded from the current state.
    always_comb begin
        fsm_state = state;
        halted    = (state == ST_HALT);
    end

    assign mode     = mode_q;
    assign obstacle = obst;

endmodule

// File: tb/tb_drive_ctrl.sv
// Directed bench for drive_ctrl with short debounce/hold/search parameters.
module tb_drive_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [19:0] distance;
    logic [1:0]  tracker_state;
    logic [1:0]  mode;
    logic [2:0]  fsm_state;
    logic        obstacle;
    logic        halted;

    int total;
    int bad;

    // Packed view of all outputs: {fsm_state, mode, obstacle, halted}.
    logic [6:0] outs;
    assign outs = {fsm_state, mode, obstacle, halted};

    drive_ctrl #(
        .OBST_CM       (20),
        .HYST_CM       (5),
        .DEB_CYCLES    (4),
        .HOLD_CYCLES   (8),
        .SEARCH_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .distance      (distance),
        .tracker_state (tracker_state),
        .mode          (mode),
        .fsm_state     (fsm_state),
        .obstacle      (obstacle),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Let n rising edges pass; outputs are then read at the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; tracker_state = 2'b00; distance = 20'd100;
        tick(2);
        total++;
        if (outs !== 7'b000_00_0_0) begin
            bad++;
            $display("FAIL reset_outputs: got st/md/ob/ht=%b want %b", outs, 7'b000_00_0_0);
        end
    endtask

    task automatic test_enable_follow();
        rst = 1'b1; enable = 1'b1; tracker_state = 2'b00; distance = 20'd100;
        tick(1);
        total++;
        if (outs !== 7'b001_00_0_0) begin
            bad++;
            $display("FAIL enter_follow: got st/md/ob/ht=%b want %b", outs, 7'b001_00_0_0);
        end
        tick(1);
        total++;
        if (outs !== 7'b001_01_0_0) begin
            bad++;
            $display("FAIL first_forward: got st/md/ob/ht=%b want %b", outs, 7'b001_01_0_0);
        end
    endtask

    task automatic test_hold();
        // Two cycles after forward was taken, a one-cycle left pulse.
        tick(2);
        tracker_state = 2'b01;
        tick(1);
        total++;
        if (mode !== 2'b01) begin
            bad++;
            $display("FAIL hold_pulse_ignored: got mode=%b want %b", mode, 2'b01);
        end
        tracker_state = 2'b00;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            total++;
            if (mode !== 2'b01) begin
                bad++;
                $display("FAIL hold_centre_cycle%0d: got mode=%b want %b", i, mode, 2'b01);
            end
        end
        // Dwell has expired; a left reading now changes mode on the next edge.
        tracker_state = 2'b01;
        tick(1);
        total++;
        if (outs !== 7'b001_10_0_0) begin
            bad++;
            $display("FAIL hold_expired_left: got st/md/ob/ht=%b want %b", outs, 7'b001_10_0_0);
        end
    endtask

    task automatic test_debounce_block();
        // Exactly at the threshold is not near.
        distance = 20'd20;
        tick(5);
        total++;
        if (obstacle !== 1'b0) begin
            bad++;
            $display("FAIL at_threshold: got obstacle=%b want 0", obstacle);
        end
        distance = 20'd19;
        tick(3);
        distance = 20'd30;
        tick(1);
        total++;
        if (outs !== 7'b001_10_0_0) begin
            bad++;
            $display("FAIL short_near_ignored: got st/md/ob/ht=%b want %b", outs, 7'b001_10_0_0);
        end
        distance = 20'd19;
        tick(3);
        total++;
        if (obstacle !== 1'b0) begin
            bad++;
            $display("FAIL near_3_cycles: got obstacle=%b want 0", obstacle);
        end
        tick(1);
        total++;
        if (outs !== 7'b001_10_1_0) begin
            bad++;
            $display("FAIL near_4_cycles: got st/md/ob/ht=%b want %b", outs, 7'b001_10_1_0);
        end
        tick(1);
        total++;
        if (outs !== 7'b010_00_1_0) begin
            bad++;
            $display("FAIL blocked_stop: got st/md/ob/ht=%b want %b", outs, 7'b010_00_1_0);
        end
        // Inside the hysteresis band the obstacle holds.
        distance = 20'd22;
        tick(6);
        total++;
        if (outs !== 7'b010_00_1_0) begin
            bad++;
            $display("FAIL band_holds: got st/md/ob/ht=%b want %b", outs, 7'b010_00_1_0);
        end
        distance = 20'd25;
        tick(4);
        total++;
        if (outs !== 7'b010_00_0_0) begin
            bad++;
            $display("FAIL clear_4_cycles: got st/md/ob/ht=%b want %b", outs, 7'b010_00_0_0);
        end
        tick(1);
        total++;
        if (outs !== 7'b001_01_0_0) begin
            bad++;
            $display("FAIL unblock_forward: got st/md/ob/ht=%b want %b", outs, 7'b001_01_0_0);
        end
    endtask

    task automatic test_search_halt();
        distance = 20'd100;
        tracker_state = 2'b10;
        tick(7);
        total++;
        if (mode !== 2'b01) begin
            bad++;
            $display("FAIL right_waits_dwell: got mode=%b want %b", mode, 2'b01);
        end
        tick(1);
        total++;
        if (mode !== 2'b11) begin
            bad++;
            $display("FAIL turn_right: got mode=%b want %b", mode, 2'b11);
        end
        tracker_state = 2'b11;
        tick(1);
        total++;
        if (outs !== 7'b011_11_0_0) begin
            bad++;
            $display("FAIL search_entry: got st/md/ob/ht=%b want %b", outs, 7'b011_11_0_0);
        end
        tick(15);
        total++;
        if (outs !== 7'b011_11_0_0) begin
            bad++;
            $display("FAIL search_15: got st/md/ob/ht=%b want %b", outs, 7'b011_11_0_0);
        end
        tick(1);
        total++;
        if (outs !== 7'b100_00_0_1) begin
            bad++;
            $display("FAIL search_timeout_halt: got st/md/ob/ht=%b want %b", outs, 7'b100_00_0_1);
        end
        // HALT ignores the tracker; only enable low leaves it.
        tracker_state = 2'b00;
        tick(2);
        total++;
        if (outs !== 7'b100_00_0_1) begin
            bad++;
            $display("FAIL halt_sticky: got st/md/ob/ht=%b want %b", outs, 7'b100_00_0_1);
        end
        enable = 1'b0;
        tick(1);
        total++;
        if (outs !== 7'b000_00_0_0) begin
            bad++;
            $display("FAIL halt_to_idle: got st/md/ob/ht=%b want %b", outs, 7'b000_00_0_0);
        end
    endtask

    task automatic test_priority_and_reset();
        enable = 1'b1; tracker_state = 2'b00; distance = 20'd100;
        tick(2);
        total++;
        if (outs !== 7'b001_01_0_0) begin
            bad++;
            $display("FAIL refollow: got st/md/ob/ht=%b want %b", outs, 7'b001_01_0_0);
        end
        distance = 20'd19;
        tick(4);
        // Obstacle is now set; tracker goes lost in the very same cycle.
        tracker_state = 2'b11;
        tick(1);
        total++;
        if (outs !== 7'b010_00_1_0) begin
            bad++;
            $display("FAIL obstacle_beats_lost: got st/md/ob/ht=%b want %b", outs, 7'b010_00_1_0);
        end
        distance = 20'd100;
        tick(5);
        total++;
        if (outs !== 7'b001_01_0_0) begin
            bad++;
            $display("FAIL unblock_while_lost: got st/md/ob/ht=%b want %b", outs, 7'b001_01_0_0);
        end
        tick(1);
        total++;
        if (outs !== 7'b011_11_0_0) begin
            bad++;
            $display("FAIL search_last_right: got st/md/ob/ht=%b want %b", outs, 7'b011_11_0_0);
        end
        distance = 20'd19;
        tick(4);
        total++;
        if (outs !== 7'b011_11_1_0) begin
            bad++;
            $display("FAIL search_obstacle_set: got st/md/ob/ht=%b want %b", outs, 7'b011_11_1_0);
        end
        rst = 1'b0;
        tick(1);
        total++;
        if (outs !== 7'b000_00_0_0) begin
            bad++;
            $display("FAIL reset_in_search: got st/md/ob/ht=%b want %b", outs, 7'b000_00_0_0);
        end
        // Last turn must be back to LEFT after reset.
        rst = 1'b1; distance = 20'd100; tracker_state = 2'b00;
        tick(2);
        tracker_state = 2'b11;
        tick(1);
        total++;
        if (outs !== 7'b011_10_0_0) begin
            bad++;
            $display("FAIL search_default_left: got st/md/ob/ht=%b want %b", outs, 7'b011_10_0_0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_enable_follow();
        test_hold();
        test_debounce_block();
        test_search_halt();
        test_priority_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drive_ctrl.md
DRIVE_CTRL -- requirements
Module: drive_ctrl

Interface
REQ-001 Parameter OBST_CM, default 20: obstacle threshold, cm.
REQ-002 Parameter HYST_CM, default 5: release hysteresis, cm.
REQ-003 Parameter DEB_CYCLES, default 1_000_000: obstacle debounce, clk cycles.
REQ-004 Parameter HOLD_CYCLES, default 2_000_000: minimum mode dwell while following, clk cycles.
REQ-005 Parameter SEARCH_CYCLES, default 100_000_000: line-lost search timeout, clk cycles.
REQ-006 Port clk, input, 1: single system clock; all logic on rising edge.
REQ-007 Port rst, input, 1: reset, synchronous, active-low.
REQ-008 Port enable, input, 1: run request; low forces stop.
REQ-009 Port distance, input, 20: ultrasonic range, unsigned cm, sampled every cycle.
REQ-010 Port tracker_state, input, 2: 00 centre, 01 line-left, 10 line-right, 11 lost.
REQ-011 Port mode, output, 2: motor command; 00 STOP, 01 FORWARD, 10 TURN_LEFT, 11 TURN_RIGHT; registered.
REQ-012 Port fsm_state, output, 3: current state encoding, for 7-seg/LED display.
REQ-013 Port obstacle, output, 1: debounced obstacle flag, registered.
REQ-014 Port halted, output, 1: high while in HALT.

Function
REQ-015 FSM states: IDLE, FOLLOW, BLOCKED, SEARCH, HALT; encodings 0-4 on fsm_state.
REQ-016 Raw near = distance < OBST_CM; raw clear = distance >= OBST_CM + HYST_CM; between the two the raw condition holds its previous value.
REQ-017 obstacle sets after raw near holds DEB_CYCLES consecutive cycles; clears after raw clear holds DEB_CYCLES consecutive cycles; any opposite sample restarts the debounce counter.
REQ-018 IDLE: mode = STOP; enable high -> FOLLOW next cycle.
REQ-019 FOLLOW: target mode from tracker: 00 -> FORWARD, 01 -> TURN_LEFT, 10 -> TURN_RIGHT; mode changes only after the current mode has been held HOLD_CYCLES cycles; hold counter restarts on every mode change.
REQ-020 FOLLOW, tracker 11 -> SEARCH, mode = last turn direction taken (TURN_LEFT if none since reset), search counter cleared.
REQ-021 SEARCH: tracker != 11 -> FOLLOW with mode = FORWARD, hold counter restarted; counter reaching SEARCH_CYCLES-1 -> HALT.
REQ-022 Obstacle asserted in FOLLOW or SEARCH -> BLOCKED with mode = STOP on the same transition; obstacle has priority over tracker and timeout events in the same cycle.
REQ-023 BLOCKED: mode = STOP; obstacle clear -> FOLLOW with mode = FORWARD, hold counter restarted; search counter not preserved.
REQ-024 HALT: mode = STOP, halted = 1; exits only when enable goes low (-> IDLE).
REQ-025 enable low in any state -> IDLE, mode = STOP next cycle; highest priority after reset.
REQ-026 All counters saturate; no wrap-around; widths sized by $clog2 of the parameter.
REQ-027 mode latency: one clk from the deciding input/counter event to mode output.

Reset
REQ-028 rst low at a rising edge: state IDLE, mode = 00, obstacle = 0, halted = 0, fsm_state = 0, all counters 0, last-turn = TURN_LEFT.
REQ-029 Reset mid-operation (any state) takes effect on the next edge with identical values; no partial state retained.

Structure
REQ-030 Mode encodings, tracker encodings and FSM state encodings belong in shared package drive_pkg, also used by the motor wrapper.
REQ-031 One sub-module drive_debounce implements REQ-016/017 (threshold compare, hysteresis, debounce counter); FSM and hold/search counters stay in drive_ctrl.

Verification (DEB=4, HOLD=8, SEARCH=16, OBST=20, HYST=5)
REQ-032 Reset then enable=1, tracker=00, distance=100 -> state FOLLOW in 1 cycle, mode=01 next cycle.
REQ-033 FOLLOW forward, tracker=01 pulsed 3 cycles after entry -> mode stays 01 until the 8-cycle hold expires, then 10 only if tracker still 01.
REQ-034 distance=19 for 3 cycles then 30 -> obstacle stays 0; distance=19 for 4 cycles -> obstacle=1, mode=00; distance=22 held -> stays BLOCKED; distance=25 for 4 cycles -> FOLLOW, mode=01.
REQ-035 After a TURN_RIGHT, tracker=11 -> SEARCH, mode=11; held 16 cycles -> HALT, halted=1, mode=00; enable=0 -> IDLE.
REQ-036 Same cycle: obstacle asserts and tracker=11 in FOLLOW -> BLOCKED, not SEARCH; rst low in SEARCH -> all outputs at reset values next edge.
